// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage owning the architectural PC.
// Issues one outstanding imem request at a time and holds the returned
// instruction in a one-entry valid/ready buffer for decode. A flush
// retargets the PC, empties the buffer and discards wrong-path responses.
// Optional build macro FETCH_PERF_EN adds perf_fetch_cnt / perf_drop_cnt.
module fetch_stage #(
    parameter int                ADDR_W   = 8,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic [ADDR_W-1:0]  pc_next,
    output logic [ADDR_W-1:0]  pc,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [ADDR_W-1:0]  imem_req_addr,
    input  logic               imem_resp_valid,
    input  logic [INSTR_W-1:0] imem_resp_data,
    output logic               if_valid,
    input  logic               if_ready,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]        perf_fetch_cnt,
    output logic [15:0]        perf_drop_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] req_pc;
    logic              drop;
    logic              buf_free;
    logic              req_fire;
    logic              resp_fire;
    logic              flush_act;
    logic              load;
    logic              discard;

    // The buffer can take a new instruction if empty or being drained now.
    assign buf_free      = !if_valid || if_ready;
    assign req_fire      = imem_req_valid && imem_req_ready;
    assign resp_fire     = (state == S_WAIT) && imem_resp_valid;
    assign flush_act     = flush && (state != S_IDLE);
    assign load          = resp_fire && !drop && !flush;
    assign discard       = resp_fire && (drop || flush);
    assign imem_req_addr = pc;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and request-valid decode.
    always_comb begin
        state_next     = state;
        imem_req_valid = 1'b0;
        case (state)
            S_IDLE: begin
                state_next = S_REQ;
            end
            S_REQ: begin
                imem_req_valid = buf_free;
                if (buf_free && imem_req_ready) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_resp_valid) begin
                    state_next = S_REQ;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // PC, in-flight bookkeeping and the one-entry output buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            req_pc   <= '0;
            drop     <= 1'b0;
            if_valid <= 1'b0;
            if_instr <= '0;
            if_pc    <= '0;
        end else begin
            if (req_fire || flush_act) begin
                pc <= pc_next;
            end
            if (req_fire) begin
                req_pc <= pc;
                drop   <= flush;
            end else if (resp_fire) begin
                drop <= 1'b0;
            end else if (flush_act && (state == S_WAIT)) begin
                drop <= 1'b1;
            end
            if (flush_act) begin
                if_valid <= 1'b0;
            end else if (load) begin
                if_valid <= 1'b1;
            end else if (if_valid && if_ready) begin
                if_valid <= 1'b0;
            end
            if (load) begin
                if_instr <= imem_resp_data;
                if_pc    <= req_pc;
            end
        end
    end

`ifdef FETCH_PERF_EN
    // Delivered-instruction and discarded-response counters, wrapping at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_cnt <= '0;
            perf_drop_cnt  <= '0;
        end else begin
            if (if_valid && if_ready) begin
                perf_fetch_cnt <= perf_fetch_cnt + 16'd1;
            end
            if (discard) begin
                perf_drop_cnt <= perf_drop_cnt + 16'd1;
            end
        end
    end
`else
    logic unused_discard;
    assign unused_discard = discard;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vector table, reset-in-WAIT sequence and a
// randomized run checked against a transaction-level fetch model.
module tb_fetch_stage;

    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 32;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               flush;
    logic [ADDR_W-1:0]  pc_next;
    logic [ADDR_W-1:0]  pc;
    logic               imem_req_valid;
    logic               imem_req_ready;
    logic [ADDR_W-1:0]  imem_req_addr;
    logic               imem_resp_valid;
    logic [INSTR_W-1:0] imem_resp_data;
    logic               if_valid;
    logic               if_ready;
    logic [INSTR_W-1:0] if_instr;
    logic [ADDR_W-1:0]  if_pc;
`ifdef FETCH_PERF_EN
    logic [15:0]        perf_fetch_cnt;
    logic [15:0]        perf_drop_cnt;
`endif

    int checks = 0;
    int errors = 0;

    fetch_stage #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .RESET_PC(8'h00)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .flush(flush),
        .pc_next(pc_next),
        .pc(pc),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data(imem_resp_data),
        .if_valid(if_valid),
        .if_ready(if_ready),
        .if_instr(if_instr),
        .if_pc(if_pc)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_cnt(perf_fetch_cnt),
        .perf_drop_cnt(perf_drop_cnt)
`endif
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    typedef struct {
        logic        fl;
        logic [7:0]  pcn;
        logic        rdy;
        logic        rv;
        logic [31:0] rd;
        logic        ir;
        logic        erqv;
        logic [7:0]  eaddr;
        logic        eifv;
        logic [7:0]  eifpc;
        logic [31:0] eifi;
    } vec_t;

    typedef struct {
        logic [7:0]  pc;
        logic [31:0] instr;
    } ent_t;

    vec_t tbl[$];

    function automatic logic [31:0] dat(input logic [7:0] a);
        return {24'hC0DE00, a};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic fl, input logic [7:0] pcn, input logic rdy,
                                 input logic rv, input logic [31:0] rd, input logic ir);
        flush           = fl;
        pc_next         = pcn;
        imem_req_ready  = rdy;
        imem_resp_valid = rv;
        imem_resp_data  = rd;
        if_ready        = ir;
    endtask

    task automatic checkCycle(input string tag, input logic erqv, input logic [7:0] eaddr,
                              input logic eifv, input logic [7:0] eifpc, input logic [31:0] eifi);
        checkOutput({tag, " pc"}, 32'(pc), 32'(eaddr));
        checkOutput({tag, " req_addr"}, 32'(imem_req_addr), 32'(eaddr));
        checkOutput({tag, " req_valid"}, 32'(imem_req_valid), 32'(erqv));
        checkOutput({tag, " if_valid"}, 32'(if_valid), 32'(eifv));
        if (eifv) begin
            checkOutput({tag, " if_pc"}, 32'(if_pc), 32'(eifpc));
            checkOutput({tag, " if_instr"}, if_instr, eifi);
        end
    endtask

    task automatic addRow(input logic fl, input logic [7:0] pcn, input logic rdy, input logic rv,
                          input logic [31:0] rd, input logic ir, input logic erqv,
                          input logic [7:0] eaddr, input logic eifv, input logic [7:0] eifpc,
                          input logic [31:0] eifi);
        vec_t v;
        v.fl = fl; v.pcn = pcn; v.rdy = rdy; v.rv = rv; v.rd = rd; v.ir = ir;
        v.erqv = erqv; v.eaddr = eaddr; v.eifv = eifv; v.eifpc = eifpc; v.eifi = eifi;
        tbl.push_back(v);
    endtask

    // Transaction-level model state for the randomized run.
    logic        m_idle;
    logic [7:0]  m_pc;
    logic        m_inflight;
    logic        m_stale;
    logic [7:0]  m_addr;
    int          m_lat;
    ent_t        m_buf[$];
    int          m_fetch_cnt;
    int          m_drop_cnt;

    initial begin
        logic        fl, rdy, rv, ir, erqv, acc, rsp, cons;
        logic [7:0]  pcn;
        logic [31:0] rd;
        ent_t        e;

        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 1'b1);

        // Columns: flush pc_next req_ready resp_valid resp_data if_ready | req_valid pc if_valid if_pc if_instr
        addRow(0, 8'h04, 1, 1, 32'hDEADBEEF, 1, 0, 8'h00, 0, 8'h00, 32'h0);
        addRow(0, 8'h04, 1, 0, 32'h0,        1, 1, 8'h00, 0, 8'h00, 32'h0);
        addRow(0, 8'h08, 1, 1, dat(8'h00),   1, 0, 8'h04, 0, 8'h00, 32'h0);
        addRow(0, 8'h08, 1, 0, 32'h0,        1, 1, 8'h04, 1, 8'h00, dat(8'h00));
        addRow(0, 8'h0C, 1, 1, dat(8'h04),   1, 0, 8'h08, 0, 8'h00, 32'h0);
        addRow(0, 8'h0C, 1, 0, 32'h0,        0, 0, 8'h08, 1, 8'h04, dat(8'h04));
        addRow(0, 8'h0C, 1, 0, 32'h0,        0, 0, 8'h08, 1, 8'h04, dat(8'h04));
        addRow(0, 8'h0C, 1, 0, 32'h0,        0, 0, 8'h08, 1, 8'h04, dat(8'h04));
        addRow(0, 8'h0C, 1, 0, 32'h0,        1, 1, 8'h08, 1, 8'h04, dat(8'h04));
        addRow(1, 8'h40, 1, 0, 32'h0,        1, 0, 8'h0C, 0, 8'h00, 32'h0);
        addRow(0, 8'h44, 1, 1, dat(8'h08),   1, 0, 8'h40, 0, 8'h00, 32'h0);
        addRow(0, 8'h44, 1, 0, 32'h0,        1, 1, 8'h40, 0, 8'h00, 32'h0);
        addRow(1, 8'hFC, 1, 1, dat(8'h40),   1, 0, 8'h44, 0, 8'h00, 32'h0);
        addRow(0, 8'h00, 0, 1, 32'h12345678, 1, 1, 8'hFC, 0, 8'h00, 32'h0);
        addRow(0, 8'h00, 1, 0, 32'h0,        1, 1, 8'hFC, 0, 8'h00, 32'h0);
        addRow(0, 8'h04, 1, 1, dat(8'hFC),   1, 0, 8'h00, 0, 8'h00, 32'h0);
        addRow(1, 8'h80, 1, 0, 32'h0,        1, 1, 8'h00, 1, 8'hFC, dat(8'hFC));
        addRow(0, 8'h84, 1, 1, dat(8'h00),   1, 0, 8'h80, 0, 8'h00, 32'h0);
        addRow(0, 8'h84, 0, 0, 32'h0,        1, 1, 8'h80, 0, 8'h00, 32'h0);
        addRow(1, 8'h20, 0, 0, 32'h0,        1, 1, 8'h80, 0, 8'h00, 32'h0);
        addRow(0, 8'h24, 1, 0, 32'h0,        1, 1, 8'h20, 0, 8'h00, 32'h0);
        addRow(0, 8'h28, 1, 1, dat(8'h20),   1, 0, 8'h24, 0, 8'h00, 32'h0);
        addRow(0, 8'h28, 0, 0, 32'h0,        1, 1, 8'h24, 1, 8'h20, dat(8'h20));
        addRow(0, 8'h28, 0, 0, 32'h0,        1, 1, 8'h24, 0, 8'h00, 32'h0);

        // Reset values while held in reset.
        repeat (2) @(negedge clk);
        #1;
        checkCycle("reset", 1'b0, 8'h00, 1'b0, 8'h00, 32'h0);
        checkOutput("reset if_instr", if_instr, 32'h0);
        checkOutput("reset if_pc", 32'(if_pc), 32'h0);

        // Directed table; release happens on the first row's falling edge.
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i].fl, tbl[i].pcn, tbl[i].rdy, tbl[i].rv, tbl[i].rd, tbl[i].ir);
            #1;
            checkCycle($sformatf("row%0d", i), tbl[i].erqv, tbl[i].eaddr, tbl[i].eifv,
                       tbl[i].eifpc, tbl[i].eifi);
            @(negedge clk);
        end

        // Reset asserted while a request is outstanding.
        applyStimulus(1'b0, 8'h2C, 1'b1, 1'b0, 32'h0, 1'b1);
        #1;
        checkOutput("rstwait accept", 32'(imem_req_valid), 32'h1);
        @(negedge clk);
        applyStimulus(1'b0, 8'h30, 1'b0, 1'b0, 32'h0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        checkCycle("rstwait async", 1'b0, 8'h00, 1'b0, 8'h00, 32'h0);
        checkOutput("rstwait if_instr", if_instr, 32'h0);
        checkOutput("rstwait if_pc", 32'(if_pc), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, 8'h04, 1'b1, 1'b1, 32'hBAD0BAD0, 1'b1);
        #1;
        checkCycle("rstwait idle", 1'b0, 8'h00, 1'b0, 8'h00, 32'h0);
        @(negedge clk);
        applyStimulus(1'b0, 8'h04, 1'b0, 1'b0, 32'h0, 1'b1);
        #1;
        checkCycle("rstwait first req", 1'b1, 8'h00, 1'b0, 8'h00, 32'h0);
        @(negedge clk);
        #1;
        checkCycle("rstwait late resp ignored", 1'b1, 8'h00, 1'b0, 8'h00, 32'h0);

        // Randomized run against the transaction-level model.
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n        = 1'b1;
        m_idle       = 1'b1;
        m_pc         = 8'h00;
        m_inflight   = 1'b0;
        m_stale      = 1'b0;
        m_addr       = 8'h00;
        m_lat        = 0;
        m_buf.delete();
        m_fetch_cnt  = 0;
        m_drop_cnt   = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            ir  = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 2) != 0);
            fl  = !m_idle && ($urandom_range(0, 9) == 0);
            pcn = fl ? (8'($urandom) & 8'hFC) : (m_pc + 8'd4);
            if (m_inflight) begin
                m_lat--;
                rv = (m_lat == 0);
            end else begin
                rv = ($urandom_range(0, 4) == 0);
            end
            rd = $urandom;
            applyStimulus(fl, pcn, rdy, rv, rd, ir);
            #1;
            erqv = !m_idle && !m_inflight && ((m_buf.size() == 0) || ir);
            if (m_buf.size() != 0) begin
                checkCycle("rand", erqv, m_pc, 1'b1, m_buf[0].pc, m_buf[0].instr);
            end else begin
                checkCycle("rand", erqv, m_pc, 1'b0, 8'h00, 32'h0);
            end
            acc  = erqv && rdy;
            rsp  = m_inflight && rv;
            cons = (m_buf.size() != 0) && ir;
            if (m_idle) begin
                m_idle = 1'b0;
            end else begin
                if (cons) begin
                    void'(m_buf.pop_front());
                    m_fetch_cnt++;
                end
                if (rsp) begin
                    if (!m_stale && !fl) begin
                        e.pc    = m_addr;
                        e.instr = rd;
                        m_buf.push_back(e);
                    end else begin
                        m_drop_cnt++;
                    end
                    m_inflight = 1'b0;
                end else if (m_inflight && fl) begin
                    m_stale = 1'b1;
                end
                if (acc) begin
                    m_inflight = 1'b1;
                    m_addr     = m_pc;
                    m_stale    = fl;
                    m_lat      = int'($urandom_range(1, 3));
                end
                if (fl) begin
                    m_buf.delete();
                end
                if (acc || fl) begin
                    m_pc = pcn;
                end
            end
            @(negedge clk);
        end
`ifdef FETCH_PERF_EN
        #1;
        checkOutput("perf_fetch_cnt", 32'(perf_fetch_cnt), 32'(m_fetch_cnt[15:0]));
        checkOutput("perf_drop_cnt", 32'(perf_drop_cnt), 32'(m_drop_cnt[15:0]));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
